fp_addsub_seq: RTL and testbench

- Multi-cycle sequencer plus datapath registers for the small floating-point add/sub unit.
- Accepts one operand pair through a valid/ready handshake. Orders the operands, aligns one bit per cycle, adds or subtracts, then normalizes one bit per cycle.
- Returns a registered result with zero, overflow and underflow flags through a second valid/ready handshake.
- Sits between the operand source (register file or test driver) and result writeback.
- Word format: {sign, exp[EXP_W-1:0], frac[MAN_W-1:0]}. Hidden bit is 1 when exp!=0. exp==0 means zero; no denormals, inf or NaN.

---
 rtl/fp_addsub_pkg.sv | 47 ++++
 rtl/fp_addsub_seq_if.sv | 29 ++
 rtl/fp_addsub_dp.sv | 172 +++++++++++++++++
 rtl/fp_addsub_seq.sv | 167 ++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the sequential floating-point add/sub unit.
// Holds the default field widths, the word payload struct, the sequencer
// state encoding, and small field-extract/pack helpers.
package fp_addsub_pkg;

    localparam int unsigned EXP_W  = 4;
    localparam int unsigned MAN_W  = 4;
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam int unsigned MANT_W = MAN_W + 1;   // mantissa with hidden bit
    localparam int unsigned SUM_W  = MAN_W + 2;   // mantissa plus carry
    localparam int unsigned CNT_W  = $clog2(MAN_W + 2);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_word_t;

    typedef enum logic [2:0] {
        IDLE,
        ORDER,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    function automatic logic fp_sign(input logic [WORD_W-1:0] w);
        return w[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [WORD_W-1:0] w);
        return w[MAN_W +: EXP_W];
    endfunction

    // Hidden bit is set for every nonzero exponent.
    function automatic logic [MANT_W-1:0] fp_mant(input logic [WORD_W-1:0] w);
        return {(|w[MAN_W +: EXP_W]), w[MAN_W-1:0]};
    endfunction

    function automatic logic [WORD_W-1:0] fp_pack(input logic             s,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [MAN_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq.
// slave  : the add/sub unit (takes operands, returns result + flags)
// master : the operand source / result consumer
interface fp_addsub_seq_if;
    import fp_addsub_pkg::*;

    logic     in_valid;
    logic     in_ready;
    fp_word_t a;
    fp_word_t b;
    logic     funct;
    logic     out_valid;
    logic     out_ready;
    fp_word_t result;
    logic     zero;
    logic     ovf;
    logic     unf;

    modport slave (
        input  in_valid, a, b, funct, out_ready,
        output in_ready, out_valid, result, zero, ovf, unf
    );

    modport master (
        output in_valid, a, b, funct, out_ready,
        input  in_ready, out_valid, result, zero, ovf, unf
    );

endinterface

// File: rtl/fp_addsub_dp.sv
// Datapath for the sequential add/sub unit: operand registers, magnitude
// compare/ordering, one-bit-per-cycle alignment shifter, adder/subtractor
// and one-bit-per-cycle normalizer. Driven by one-hot strobes from the
// sequencer; reports status and candidate result words back to it.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load/order/align/add/norm  per-state strobes
//   a, b, funct          operands and operation, captured on load
//   special_*_c          early-exit decision and word (valid in ORDER)
//   d_zero_c, cnt_last_c alignment distance status
//   norm_*_c             normalizer exit decision, word and flags
module fp_addsub_dp
    import fp_addsub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              order,
    input  logic              align,
    input  logic              add,
    input  logic              norm,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              funct,
    output logic              special_c,
    output logic              special_zero_c,
    output logic [WORD_W-1:0] special_word_c,
    output logic              d_zero_c,
    output logic              cnt_last_c,
    output logic              norm_done_c,
    output logic              norm_ovf_c,
    output logic              norm_unf_c,
    output logic [WORD_W-1:0] norm_word_c
);

    localparam logic [EXP_W-1:0] D_MAX = EXP_W'(MAN_W + 1);

    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              funct_q;
    logic              sign_l;
    logic              eff_sub;
    logic [MANT_W-1:0] mant_l;
    logic [MANT_W-1:0] mant_s;
    logic [EXP_W-1:0]  exp_l;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  sum;

    logic              sign_a;
    logic              sign_b;
    logic              eff_sub_c;
    logic              a_is_l;
    logic              equal_mag;
    logic              sign_big;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [EXP_W-1:0]  exp_big;
    logic [EXP_W-1:0]  exp_small;
    logic [EXP_W-1:0]  exp_diff;
    logic [MANT_W-1:0] man_a;
    logic [MANT_W-1:0] man_b;
    logic [MANT_W-1:0] man_big;
    logic [MANT_W-1:0] man_small;
    logic [CNT_W-1:0]  d_c;

    logic              carry;
    logic              msb;
    logic              exp_max;
    logic              exp_one;

    // Operand ordering and early-exit detection from the latched operands.
    always_comb begin
        sign_a    = fp_sign(op_a);
        sign_b    = fp_sign(op_b) ^ funct_q;
        exp_a     = fp_exp(op_a);
        exp_b     = fp_exp(op_b);
        man_a     = fp_mant(op_a);
        man_b     = fp_mant(op_b);
        eff_sub_c = sign_a ^ sign_b;
        a_is_l    = {exp_a, man_a} >= {exp_b, man_b};
        equal_mag = {exp_a, man_a} == {exp_b, man_b};
        if (a_is_l) begin
            sign_big  = sign_a;
            exp_big   = exp_a;
            man_big   = man_a;
            exp_small = exp_b;
            man_small = man_b;
        end else begin
            sign_big  = sign_b;
            exp_big   = exp_b;
            man_big   = man_b;
            exp_small = exp_a;
            man_small = man_a;
        end
        exp_diff       = exp_big - exp_small;
        // Beyond MANT_W shifts the smaller mantissa is already all zeros.
        d_c            = (exp_diff > D_MAX) ? CNT_W'(D_MAX) : CNT_W'(exp_diff);
        d_zero_c       = (d_c == '0);
        special_zero_c = (exp_big == '0) || (eff_sub_c && equal_mag);
        special_c      = (exp_small == '0) || (eff_sub_c && equal_mag);
        special_word_c = special_zero_c ? '0
                                        : fp_pack(sign_big, exp_big, man_big[MAN_W-1:0]);
    end

    assign cnt_last_c = (cnt == CNT_W'(1));

    // Normalizer decision for the current cycle's sum/exponent.
    always_comb begin
        carry       = sum[SUM_W-1];
        msb         = sum[MAN_W];
        exp_max     = &exp_l;
        exp_one     = (exp_l == EXP_W'(1));
        norm_done_c = carry || msb || exp_one;
        norm_ovf_c  = carry && exp_max;
        norm_unf_c  = !carry && !msb && exp_one;
        norm_word_c = '0;
        if (carry) begin
            norm_word_c = exp_max ? fp_pack(sign_l, '1, '1)
                                  : fp_pack(sign_l, exp_l + EXP_W'(1), sum[MAN_W:1]);
        end else if (msb) begin
            norm_word_c = fp_pack(sign_l, exp_l, sum[MAN_W-1:0]);
        end
    end

    // Datapath registers; strobes are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            funct_q <= 1'b0;
            sign_l  <= 1'b0;
            eff_sub <= 1'b0;
            mant_l  <= '0;
            mant_s  <= '0;
            exp_l   <= '0;
            cnt     <= '0;
            sum     <= '0;
        end else begin
            if (load) begin
                op_a    <= a;
                op_b    <= b;
                funct_q <= funct;
            end
            if (order) begin
                sign_l  <= sign_big;
                eff_sub <= eff_sub_c;
                mant_l  <= man_big;
                mant_s  <= man_small;
                exp_l   <= exp_big;
                cnt     <= d_c;
            end
            if (align) begin
                mant_s <= mant_s >> 1;
                cnt    <= cnt - CNT_W'(1);
            end
            if (add) begin
                sum <= eff_sub ? (SUM_W'(mant_l) - SUM_W'(mant_s))
                               : (SUM_W'(mant_l) + SUM_W'(mant_s));
            end
            if (norm) begin
                if (carry) begin
                    sum   <= sum >> 1;
                    exp_l <= exp_l + EXP_W'(1);
                end else if (!msb) begin
                    sum   <= sum << 1;
                    exp_l <= exp_l - EXP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point add/sub unit: handshake + FSM around
// fp_addsub_dp. Accepts one operand pair, orders, aligns and normalizes
// one bit per cycle, and holds a registered result with flags until the
// consumer accepts it.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  fp_addsub_seq_if.slave: in_valid/in_ready/a/b/funct in,
//        out_valid/out_ready/result/zero/ovf/unf out
module fp_addsub_seq
    import fp_addsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fp_addsub_seq_if.slave   bus
);

    state_t            state;
    state_t            state_next;

    logic              load;
    logic              order;
    logic              align;
    logic              add;
    logic              norm;
    logic              cap;
    logic [WORD_W-1:0] cap_word;
    logic              cap_zero;
    logic              cap_ovf;
    logic              cap_unf;

    logic              special_c;
    logic              special_zero_c;
    logic [WORD_W-1:0] special_word_c;
    logic              d_zero_c;
    logic              cnt_last_c;
    logic              norm_done_c;
    logic              norm_ovf_c;
    logic              norm_unf_c;
    logic [WORD_W-1:0] norm_word_c;

    logic              out_valid_q;
    fp_word_t          result_q;
    logic              zero_q;
    logic              ovf_q;
    logic              unf_q;

    fp_addsub_dp u_dp (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .order          (order),
        .align          (align),
        .add            (add),
        .norm           (norm),
        .a              (bus.a),
        .b              (bus.b),
        .funct          (bus.funct),
        .special_c      (special_c),
        .special_zero_c (special_zero_c),
        .special_word_c (special_word_c),
        .d_zero_c       (d_zero_c),
        .cnt_last_c     (cnt_last_c),
        .norm_done_c    (norm_done_c),
        .norm_ovf_c     (norm_ovf_c),
        .norm_unf_c     (norm_unf_c),
        .norm_word_c    (norm_word_c)
    );

    // Next-state, datapath strobes and result capture.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        order      = 1'b0;
        align      = 1'b0;
        add        = 1'b0;
        norm       = 1'b0;
        cap        = 1'b0;
        cap_word   = '0;
        cap_zero   = 1'b0;
        cap_ovf    = 1'b0;
        cap_unf    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = ORDER;
                end
            end
            ORDER: begin
                order = 1'b1;
                if (special_c) begin
                    cap        = 1'b1;
                    cap_word   = special_word_c;
                    cap_zero   = special_zero_c;
                    state_next = DONE;
                end else if (d_zero_c) begin
                    state_next = ADD;
                end else begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                align = 1'b1;
                if (cnt_last_c) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                add        = 1'b1;
                state_next = NORM;
            end
            NORM: begin
                norm = 1'b1;
                if (norm_done_c) begin
                    cap        = 1'b1;
                    cap_word   = norm_word_c;
                    cap_zero   = norm_unf_c;
                    cap_ovf    = norm_ovf_c;
                    cap_unf    = norm_unf_c;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, output-valid and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next == DONE);
            if (load) begin
                zero_q <= 1'b0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end
            if (cap) begin
                result_q <= cap_word;
                zero_q   <= cap_zero;
                ovf_q    <= cap_ovf;
                unf_q    <= cap_unf;
            end
        end
    end

    // in_ready drops immediately while reset is held.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed vector table, hold and
// mid-operation reset sequences, and randomized operands against an
// arithmetic reference model.
module tb_fp_addsub_seq;
    import fp_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_seq_if bus();

    fp_addsub_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic       f;
        logic [8:0] r;
        logic       z;
        logic       o;
        logic       u;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [8:0] pack(input int s, input int e, input int f);
        return 9'((s << 8) | (e << 4) | f);
    endfunction

    // Reference: value = mant * 2^exp with hidden bit, truncating alignment,
    // renormalize to a leading one in bit 4; latency from the cycle budget
    // ORDER + min(d,5) align cycles + ADD + normalize checks.
    function automatic void model(input logic [8:0] a, input logic [8:0] b, input logic f,
                                  output logic [8:0] r, output logic z, output logic o,
                                  output logic u, output int lat);
        int sa, sb, ea, eb, ma, mb, sl, el, ml, es, ms, s, k, n, sh, dcap;
        bit eff;
        sa = int'(a[8]);
        sb = int'(b[8] ^ f);
        ea = int'(a[7:4]);
        eb = int'(b[7:4]);
        ma = int'(a[3:0]) + ((ea != 0) ? 16 : 0);
        mb = int'(b[3:0]) + ((eb != 0) ? 16 : 0);
        eff = (sa != sb);
        z = 1'b0; o = 1'b0; u = 1'b0; r = '0;
        if (ea * 32 + ma >= eb * 32 + mb) begin
            sl = sa; el = ea; ml = ma; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb; es = ea; ms = ma;
        end
        if (es == 0 || (eff && ea == eb && ma == mb)) begin
            lat = 1;
            if (es == 0 && el != 0) r = pack(sl, el, ml & 15);
            else begin r = '0; z = 1'b1; end
        end else begin
            sh   = el - es;
            dcap = (sh > 5) ? 5 : sh;
            ms   = ms >> sh;
            s    = eff ? ml - ms : ml + ms;
            n    = 1;
            if (s >= 32) begin
                if (el + 1 > 15) begin r = pack(sl, 15, 15); o = 1'b1; end
                else r = pack(sl, el + 1, (s >> 1) & 15);
            end else if (s >= 16) begin
                r = pack(sl, el, s & 15);
            end else begin
                k = 0;
                while (((s << k) < 16) && k < 8) k++;
                if (el <= k) begin
                    r = '0; z = 1'b1; u = 1'b1; n = el;
                end else begin
                    r = pack(sl, el - k, (s << k) & 15);
                    n = k + 1;
                end
            end
            lat = 2 + dcap + n;
        end
    endfunction

    // One full transaction with expected values; hold = cycles with out_ready low in DONE.
    task automatic run_op(input string tag, input logic [8:0] a, input logic [8:0] b,
                          input logic f, input int hold, input logic [8:0] er,
                          input logic ez, input logic eo, input logic eu, input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.a         = a;
        bus.b         = b;
        bus.funct     = f;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.out_valid) check({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        end while (!bus.out_valid && lat < 64);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".result"}, 32'(bus.result), 32'(er));
        check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        check({tag, ".unf"}, 32'(bus.unf), 32'(eu));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, ".hold_result"}, 32'(bus.result), 32'(er));
            check({tag, ".hold_flags"}, 32'({bus.zero, bus.ovf, bus.unf}), 32'({ez, eo, eu}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".released"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    // in_ready and out_valid must never be high together.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (bus.in_ready && bus.out_valid) begin
                failures++;
                $display("FAIL ready_valid_exclusive: in_ready=1 out_valid=1 expected not both");
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] ra, rb, er;
        logic       rf, ez, eo, eu;
        int         elat;
        bit         quiet;

        //            a       b       f     result  z     o     u     lat
        vecs[0]  = '{9'h070, 9'h070, 1'b0, 9'h080, 1'b0, 1'b0, 1'b0, 3};
        vecs[1]  = '{9'h070, 9'h070, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{9'h078, 9'h050, 1'b0, 9'h07C, 1'b0, 1'b0, 1'b0, 5};
        vecs[3]  = '{9'h071, 9'h070, 1'b1, 9'h030, 1'b0, 1'b0, 1'b0, 7};
        vecs[4]  = '{9'h011, 9'h010, 1'b1, 9'h000, 1'b1, 1'b0, 1'b1, 3};
        vecs[5]  = '{9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0, 3};
        vecs[6]  = '{9'h000, 9'h070, 1'b1, 9'h170, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{9'h000, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{9'h170, 9'h070, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{9'h0F0, 9'h010, 1'b0, 9'h0F0, 1'b0, 1'b0, 1'b0, 8};
        vecs[10] = '{9'h050, 9'h178, 1'b0, 9'h174, 1'b0, 1'b0, 1'b0, 5};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.funct     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.in_ready_during_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.flags", 32'({bus.zero, bus.ovf, bus.unf}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f, 0,
                   vecs[i].r, vecs[i].z, vecs[i].o, vecs[i].u, vecs[i].lat);
        end

        // Consumer stalls for 10 cycles in DONE.
        run_op("hold", vecs[2].a, vecs[2].b, vecs[2].f, 10,
               vecs[2].r, vecs[2].z, vecs[2].o, vecs[2].u, vecs[2].lat);

        // Reset pulse during ALIGN discards the operation.
        @(negedge clk);
        bus.a        = 9'h0F0;
        bus.b        = 9'h010;
        bus.funct    = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.in_ready_during_rst", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst.result", 32'(bus.result), 32'd0);
        check("midrst.flags", 32'({bus.zero, bus.ovf, bus.unf}), 32'd0);
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || !bus.in_ready) quiet = 1'b0;
        end
        check("midrst.no_output", 32'(quiet), 32'd1);
        run_op("after_rst", vecs[3].a, vecs[3].b, vecs[3].f, 0,
               vecs[3].r, vecs[3].z, vecs[3].o, vecs[3].u, vecs[3].lat);

        // Randomized operands; some pairs share the upper bits to exercise cancellation.
        for (int i = 0; i < 300; i++) begin
            ra = 9'($urandom);
            rb = 9'($urandom);
            if ($urandom_range(0, 3) == 0) rb = {rb[8], ra[7:2], rb[1:0]};
            rf = 1'($urandom);
            model(ra, rb, rf, er, ez, eo, eu, elat);
            run_op($sformatf("rand%0d", i), ra, rb, rf, $urandom_range(0, 2),
                   er, ez, eo, eu, elat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
